// File: rtl/xbus_target_decoder.sv
// X-bus target decoder: routes CPU bus requests to internal RAM,
// the external IO port, or an error responder for unmapped space.
module xbus_target_decoder #(
    parameter int          RAMW       = 12,
    parameter int          IO_TIMEOUT = 255,
    parameter logic [31:0] ERR_DATA   = 32'hFFFFFFFF
) (
    input  logic        CLK,
    input  logic        RESN,
    input  logic        XDREQ,
    input  logic        XWR,
    input  logic        XRD,
    input  logic [3:0]  XBE,
    input  logic [31:0] XADDR,
    input  logic [31:0] XATAO,
    output logic [31:0] XATAI,
    output logic        XDACK,
    output logic        IOREQ,
    output logic        IOWR,
    output logic        IORD,
    output logic [3:0]  IOBE,
    output logic [31:0] IOADDR,
    output logic [31:0] IODATAO,
    input  logic [31:0] IODATAI,
    input  logic        IOACK,
    output logic        BERR,
    output logic [7:0]  ERRCNT
);

    typedef enum logic [1:0] {
        IDLE,
        RAMACC,
        IOWAIT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic [31:0]     mem [0:(1<<RAMW)-1];
    logic [31:0]     ram_q;
    logic [RAMW-1:0] widx;

    logic [15:0]     cnt;
    logic [15:0]     cnt_dec;

    logic            is_ram;
    logic            is_io;
    logic            take;
    logic            ram_go;
    logic            io_tmo;
    logic            berr_set;

    assign widx     = XADDR[RAMW+1:2];
    assign is_ram   = (XADDR[31:30] == 2'b00);
    assign is_io    = (XADDR[31:30] == 2'b10);
    assign take     = (state == IDLE) && XDREQ;
    assign ram_go   = RESN && take && is_ram;
    assign cnt_dec  = cnt - 16'd1;
    assign io_tmo   = (state == IOWAIT) && !IOACK && (cnt_dec == 16'd0);
    assign berr_set = (take && !is_ram && !is_io) || io_tmo;

    // Next-state logic; DONE never looks at XDREQ so a held request
    // of the transfer just acknowledged is not serviced twice.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (XDREQ) begin
                    if (is_ram) begin
                        state_nx = RAMACC;
                    end else if (is_io) begin
                        state_nx = IOWAIT;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            RAMACC: state_nx = DONE;
            IOWAIT: begin
                if (IOACK || (cnt_dec == 16'd0)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESN) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Bus-side and IO-side registered outputs; ack/error are one-cycle pulses.
    always_ff @(posedge CLK) begin
        if (!RESN) begin
            XDACK   <= 1'b0;
            BERR    <= 1'b0;
            XATAI   <= 32'd0;
            IOREQ   <= 1'b0;
            IOWR    <= 1'b0;
            IORD    <= 1'b0;
            IOBE    <= 4'd0;
            IOADDR  <= 32'd0;
            IODATAO <= 32'd0;
            cnt     <= 16'd0;
        end else begin
            XDACK <= 1'b0;
            BERR  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (XDREQ && is_io) begin
                        IOREQ   <= 1'b1;
                        IOWR    <= XWR;
                        IORD    <= XRD;
                        IOBE    <= XBE;
                        IOADDR  <= XADDR;
                        IODATAO <= XATAO;
                        cnt     <= 16'(IO_TIMEOUT);
                    end else if (XDREQ && !is_ram) begin
                        XDACK <= 1'b1;
                        BERR  <= 1'b1;
                        XATAI <= ERR_DATA;
                    end
                end
                RAMACC: begin
                    XDACK <= 1'b1;
                    XATAI <= ram_q;
                end
                IOWAIT: begin
                    if (IOACK) begin
                        IOREQ <= 1'b0;
                        IOWR  <= 1'b0;
                        IORD  <= 1'b0;
                        XDACK <= 1'b1;
                        XATAI <= IODATAI;
                    end else begin
                        cnt <= cnt_dec;
                        if (cnt_dec == 16'd0) begin
                            IOREQ <= 1'b0;
                            XDACK <= 1'b1;
                            BERR  <= 1'b1;
                            XATAI <= ERR_DATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating bus-error counter, stepped with every BERR pulse.
    always_ff @(posedge CLK) begin
        if (!RESN) begin
            ERRCNT <= 8'd0;
        end else if (berr_set && (ERRCNT != 8'hFF)) begin
            ERRCNT <= ERRCNT + 8'd1;
        end
    end

    // RAM port: read-before-write so the ack carries the old word;
    // contents survive reset.
    always_ff @(posedge CLK) begin
        if (ram_go) begin
            ram_q <= mem[widx];
            if (XWR) begin
                for (int i = 0; i < 4; i++) begin
                    if (XBE[i]) begin
                        mem[widx][8*i +: 8] <= XATAO[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xbus_target_decoder.sv
// Bench for xbus_target_decoder: transaction-level expectations are
// scheduled per cycle and compared against the DUT on every negedge.
module tb_xbus_target_decoder;

    localparam int          RAMW = 12;
    localparam int          TMO  = 4;
    localparam logic [31:0] ERRD = 32'hFFFFFFFF;

    logic        CLK = 1'b0;
    logic        RESN = 1'b0;
    logic        XDREQ = 1'b0;
    logic        XWR = 1'b0;
    logic        XRD = 1'b0;
    logic [3:0]  XBE = 4'd0;
    logic [31:0] XADDR = 32'd0;
    logic [31:0] XATAO = 32'd0;
    logic [31:0] XATAI;
    logic        XDACK;
    logic        IOREQ;
    logic        IOWR;
    logic        IORD;
    logic [3:0]  IOBE;
    logic [31:0] IOADDR;
    logic [31:0] IODATAO;
    logic [31:0] IODATAI = 32'd0;
    logic        IOACK = 1'b0;
    logic        BERR;
    logic [7:0]  ERRCNT;

    xbus_target_decoder #(
        .RAMW(RAMW),
        .IO_TIMEOUT(TMO),
        .ERR_DATA(ERRD)
    ) dut (
        .CLK(CLK),
        .RESN(RESN),
        .XDREQ(XDREQ),
        .XWR(XWR),
        .XRD(XRD),
        .XBE(XBE),
        .XADDR(XADDR),
        .XATAO(XATAO),
        .XATAI(XATAI),
        .XDACK(XDACK),
        .IOREQ(IOREQ),
        .IOWR(IOWR),
        .IORD(IORD),
        .IOBE(IOBE),
        .IOADDR(IOADDR),
        .IODATAO(IODATAO),
        .IODATAI(IODATAI),
        .IOACK(IOACK),
        .BERR(BERR),
        .ERRCNT(ERRCNT)
    );

    always #5 CLK = ~CLK;

    // Edge counter: outputs produced by edge e are sampled in slot e+1.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Per-slot expectations; absent key means "low".
    bit          s_ack  [int];
    bit          s_berr [int];
    bit          s_ioreq[int];
    bit          s_rst  [int];
    bit          s_dchk [int];
    logic [31:0] s_dat  [int];

    logic        e_iowr = 1'b0;
    logic        e_iord = 1'b0;
    logic [3:0]  e_iobe = 4'd0;
    logic [31:0] e_ioaddr = 32'd0;
    logic [31:0] e_iodat = 32'd0;

    // Reference RAM: word index -> fully known word.
    logic [31:0] mem_m[int];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s slot=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endfunction

    logic [31:0] last_dat = 32'd0;
    bit          dat_known = 1'b1;
    int          err_m = 0;
    bit          ca, cb, cr;

    // Compare process: one sample per cycle on the falling edge.
    always @(negedge CLK) begin
        if (cyc >= 1) begin
            ca = s_ack.exists(cyc);
            cb = s_berr.exists(cyc);
            cr = s_ioreq.exists(cyc);
            if (s_rst.exists(cyc)) begin
                last_dat  = 32'd0;
                dat_known = 1'b1;
                err_m     = 0;
                chk("rst_IOWR", 32'(IOWR), 32'd0);
                chk("rst_IORD", 32'(IORD), 32'd0);
                chk("rst_IOBE", 32'(IOBE), 32'd0);
                chk("rst_IOADDR", IOADDR, 32'd0);
                chk("rst_IODATAO", IODATAO, 32'd0);
            end
            if (ca) begin
                if (s_dchk.exists(cyc)) begin
                    last_dat  = s_dat[cyc];
                    dat_known = 1'b1;
                end else begin
                    dat_known = 1'b0;
                end
            end
            if (cb && err_m < 255) err_m++;
            chk("XDACK", 32'(XDACK), 32'(ca));
            chk("BERR", 32'(BERR), 32'(cb));
            chk("IOREQ", 32'(IOREQ), 32'(cr));
            chk("ERRCNT", 32'(ERRCNT), 32'(err_m));
            if (dat_known) chk("XATAI", XATAI, last_dat);
            if (cr) begin
                chk("IOWR", 32'(IOWR), 32'(e_iowr));
                chk("IORD", 32'(IORD), 32'(e_iord));
                chk("IOBE", 32'(IOBE), 32'(e_iobe));
                chk("IOADDR", IOADDR, e_ioaddr);
                chk("IODATAO", IODATAO, e_iodat);
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    // One bus transfer. iod = cycle (relative to the request edge) on
    // which the IO side raises IOACK; iod outside 1..TMO means timeout.
    task automatic txn(input logic [31:0] addr, input bit wr, input bit rd,
                       input logic [3:0] be, input logic [31:0] wd,
                       input int iod, input logic [31:0] iodata,
                       input bit use_lit, input logic [31:0] lit);
        int          S;
        int          A;
        int          w;
        bit          io;
        bit          berr;
        bit          dchk;
        logic [31:0] exp;
        logic [31:0] nv;
        S     = cyc;
        XDREQ = 1'b1;
        XWR   = wr;
        XRD   = rd;
        XBE   = be;
        XADDR = addr;
        XATAO = wd;
        io    = 1'b0;
        berr  = 1'b0;
        dchk  = 1'b1;
        exp   = ERRD;
        if (addr[31:30] == 2'b00) begin
            w = int'(addr[RAMW+1:2]);
            A = S + 2;
            if (mem_m.exists(w)) begin
                exp = mem_m[w];
            end else begin
                exp  = 32'd0;
                dchk = 1'b0;
            end
            if (wr) begin
                if (mem_m.exists(w)) begin
                    nv = mem_m[w];
                    for (int i = 0; i < 4; i++)
                        if (be[i]) nv[8*i +: 8] = wd[8*i +: 8];
                    mem_m[w] = nv;
                end else if (be == 4'hF) begin
                    mem_m[w] = wd;
                end
            end
        end else if (addr[31:30] == 2'b10) begin
            io       = 1'b1;
            e_iowr   = wr;
            e_iord   = rd;
            e_iobe   = be;
            e_ioaddr = addr;
            e_iodat  = wd;
            if (iod >= 1 && iod <= TMO) begin
                A   = S + iod + 1;
                exp = iodata;
            end else begin
                A    = S + TMO + 1;
                berr = 1'b1;
            end
            for (int k = S + 1; k < A; k++) s_ioreq[k] = 1'b1;
        end else begin
            A    = S + 1;
            berr = 1'b1;
        end
        if (use_lit) chk("model_lit", exp, lit);
        s_ack[A] = 1'b1;
        if (berr) s_berr[A] = 1'b1;
        if (dchk) begin
            s_dchk[A] = 1'b1;
            s_dat[A]  = exp;
        end
        for (int k = S + 1; k <= A + 1; k++) begin
            step();
            IOACK = io && (k == S + iod);
            if (IOACK) IODATAI = iodata;
            if (k == A + 1) begin
                XDREQ = 1'b0;
                XWR   = 1'b0;
                XRD   = 1'b0;
            end
        end
    endtask

    logic [31:0] ra;
    int          sel;
    int          S0;

    initial begin
        step();
        s_rst[1] = 1'b1;
        s_rst[2] = 1'b1;
        step();
        RESN = 1'b1;

        txn(32'h00000010, 1, 0, 4'hF, 32'hCAFEBABE, 0, 0, 0, 0);
        txn(32'h00000010, 0, 1, 4'h0, 32'h0, 0, 0, 1, 32'hCAFEBABE);
        txn(32'h00000010, 1, 0, 4'b0010, 32'h00001200, 0, 0, 1, 32'hCAFEBABE);
        txn(32'h00000010, 0, 1, 4'h0, 32'h0, 0, 0, 1, 32'hCAFE12BE);
        txn(32'h00000010 + (32'd1 << (RAMW + 2)), 0, 1, 4'h0, 32'h0, 0, 0,
            1, 32'hCAFE12BE);
        txn(32'h00000010, 0, 0, 4'h0, 32'h0, 0, 0, 1, 32'hCAFE12BE);
        txn(32'h80000004, 0, 1, 4'hF, 32'h0, 4, 32'h12345678, 1, 32'h12345678);
        txn(32'h80000010, 1, 0, 4'h5, 32'hA5A5A5A5, 0, 0, 1, 32'hFFFFFFFF);
        chk("errcnt_after_tmo", 32'(ERRCNT), 32'd1);
        txn(32'h40000000, 0, 1, 4'h0, 32'h0, 0, 0, 1, 32'hFFFFFFFF);
        chk("errcnt_after_unmapped", 32'(ERRCNT), 32'd2);

        // Reset while waiting on IO with the request still held.
        S0       = cyc;
        XDREQ    = 1'b1;
        XRD      = 1'b1;
        XWR      = 1'b0;
        XBE      = 4'hF;
        XADDR    = 32'h80000008;
        XATAO    = 32'h0;
        e_iowr   = 1'b0;
        e_iord   = 1'b1;
        e_iobe   = 4'hF;
        e_ioaddr = 32'h80000008;
        e_iodat  = 32'h0;
        s_ioreq[S0 + 1] = 1'b1;
        s_ioreq[S0 + 2] = 1'b1;
        step();
        step();
        RESN = 1'b0;
        s_rst[cyc + 1] = 1'b1;
        step();
        RESN  = 1'b1;
        XDREQ = 1'b0;
        XRD   = 1'b0;
        step();
        txn(32'h00000010, 0, 1, 4'h0, 32'h0, 0, 0, 1, 32'hCAFE12BE);

        for (int i = 0; i < 16; i++)
            txn({2'b00, 16'($urandom), 12'(i * 257), 2'b00}, 1, 0, 4'hF,
                $urandom, 0, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                ra = {2'b00, 16'($urandom), 12'($urandom_range(0, 15) * 257),
                      2'b00};
            end else if (sel < 8) begin
                ra = {2'b10, 30'($urandom)};
            end else begin
                ra = {($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01,
                      30'($urandom)};
            end
            txn(ra, 1'($urandom), 1'($urandom), 4'($urandom), $urandom,
                $urandom_range(0, 6), $urandom, 0, 0);
            repeat ($urandom_range(0, 2)) begin
                step();
                IOACK   = ($urandom_range(0, 3) == 0);
                IODATAI = $urandom;
            end
            IOACK = 1'b0;
        end

        for (int n = 0; n < 256; n++)
            txn({(n % 2 == 0) ? 2'b01 : 2'b11, 30'($urandom)}, 0, 1, 4'h0,
                32'h0, 0, 0, 0, 0);
        chk("errcnt_saturated", 32'(ERRCNT), 32'd255);

        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
